// File: rtl/shift_arbiter_pkg.sv
// Shared definitions for the shift_arbiter block.
//   state_t       : FSM state encoding (IDLE -> SHIFT -> RESP -> IDLE)
//   DATA_W        : operand / result width
//   AMT_W         : width of the barrel shifter amount
//   BIG_THRESHOLD : shift amounts at or above this value produce zero
//   is_big()      : classifies a full 32-bit shift amount against BIG_THRESHOLD
package shift_arbiter_pkg;

    localparam int DATA_W = 32;
    localparam int AMT_W  = 5;
    localparam logic [DATA_W-1:0] BIG_THRESHOLD = 32'd32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        RESP  = 2'd2
    } state_t;

    // Any amount that cannot be expressed in AMT_W bits shifts every bit out.
    function automatic logic is_big(input logic [DATA_W-1:0] amount);
        return (amount >= BIG_THRESHOLD);
    endfunction

endpackage

// File: rtl/shift_arbiter_barrel_shifter32.sv
// 32-bit logical barrel shifter, purely combinational.
// Ports:
//   d   : data operand
//   s   : shift amount 0..31
//   lnr : direction, 1 = left, 0 = right (zero fill both ways)
//   y   : shifted result
module barrel_shifter32
    import shift_arbiter_pkg::*;
(
    input  logic [DATA_W-1:0] d,
    input  logic [AMT_W-1:0]  s,
    input  logic              lnr,
    output logic [DATA_W-1:0] y
);

    // Five log-spaced stages; stage k moves the word by 2**k when s[k] is set.
    logic [AMT_W:0][DATA_W-1:0] stage;

    assign stage[0] = d;

    for (genvar k = 0; k < AMT_W; k++) begin : g_stage
        localparam int SH = 1 << k;
        logic [DATA_W-1:0] moved;
        assign moved = lnr ? {stage[k][DATA_W-1-SH:0], {SH{1'b0}}}
                           : {{SH{1'b0}}, stage[k][DATA_W-1:SH]};
        assign stage[k+1] = s[k] ? moved : stage[k];
    end

    assign y = stage[AMT_W];

endmodule

// File: rtl/shift_arbiter.sv
// Two-requester round-robin arbiter in front of a single barrel shifter.
// One operation is in flight at a time: accept in IDLE, compute in SHIFT,
// present the result in RESP until the consumer takes it.
// Ports:
//   clk, rst                       : clock, async active-high reset
//   reqN_valid/_d/_s/_lnr/_ready   : requester N (0 or 1) handshake and operands
//   rsp_valid/_id/_y/_ready        : result handshake, owning requester and data
// Parameter:
//   RR_INIT : requester that wins the first contention after reset
module shift_arbiter
    import shift_arbiter_pkg::*;
#(
    parameter bit RR_INIT = 1'b0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    input  logic [DATA_W-1:0] req0_d,
    input  logic [DATA_W-1:0] req0_s,
    input  logic              req0_lnr,
    output logic              req0_ready,
    input  logic              req1_valid,
    input  logic [DATA_W-1:0] req1_d,
    input  logic [DATA_W-1:0] req1_s,
    input  logic              req1_lnr,
    output logic              req1_ready,
    output logic              rsp_valid,
    output logic              rsp_id,
    output logic [DATA_W-1:0] rsp_y,
    input  logic              rsp_ready
);

    state_t            state;
    state_t            next_state;
    logic [DATA_W-1:0] d_reg;
    logic [AMT_W-1:0]  s_reg;
    logic              lnr_reg;
    logic              id_reg;
    logic              big_reg;
    logic              last_served;
    logic              grant0;
    logic              grant1;
    logic              accept;
    logic [DATA_W-1:0] shift_out;

    // Requester 1 wins when it is alone, or when both ask and 0 was served last.
    always_comb begin
        grant1 = req1_valid & (~req0_valid | ~last_served);
        grant0 = req0_valid & ~grant1;
    end

    // Grants are mutually exclusive, so at most one ready can be high.
    assign req0_ready = (state == IDLE) & req0_valid & grant0 & ~rst;
    assign req1_ready = (state == IDLE) & req1_valid & grant1 & ~rst;
    assign accept     = req0_ready | req1_ready;
    assign rsp_valid  = (state == RESP);

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic: one cycle to shift, then wait for the consumer.
    always_comb begin
        next_state = state;
        case (state)
            IDLE:    if (accept) next_state = SHIFT;
            SHIFT:   next_state = RESP;
            RESP:    if (rsp_ready) next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    // Capture the winning requester's operands so later input changes
    // cannot disturb the operation in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_reg       <= '0;
            s_reg       <= '0;
            lnr_reg     <= 1'b0;
            id_reg      <= 1'b0;
            big_reg     <= 1'b0;
            last_served <= ~RR_INIT;
        end else if (accept) begin
            d_reg       <= req1_ready ? req1_d : req0_d;
            s_reg       <= req1_ready ? req1_s[AMT_W-1:0] : req0_s[AMT_W-1:0];
            lnr_reg     <= req1_ready ? req1_lnr : req0_lnr;
            big_reg     <= req1_ready ? is_big(req1_s) : is_big(req0_s);
            id_reg      <= req1_ready;
            last_served <= req1_ready;
        end
    end

    barrel_shifter32 u_shifter (
        .d   (d_reg),
        .s   (s_reg),
        .lnr (lnr_reg),
        .y   (shift_out)
    );

    // Result register is only written in SHIFT, so it holds through RESP.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rsp_y  <= '0;
            rsp_id <= 1'b0;
        end else if (state == SHIFT) begin
            rsp_y  <= big_reg ? '0 : shift_out;
            rsp_id <= id_reg;
        end
    end

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed, self-checking bench for shift_arbiter (RR_INIT = 0).
// Expected results are computed by a reference shift model when a request is
// accepted, queued, and compared when the response handshake completes.
module tb_shift_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic        req0_valid, req0_lnr, req0_ready;
    logic [31:0] req0_d, req0_s;
    logic        req1_valid, req1_lnr, req1_ready;
    logic [31:0] req1_d, req1_s;
    logic        rsp_valid, rsp_id, rsp_ready;
    logic [31:0] rsp_y;

    typedef struct packed {
        logic        id;
        logic [31:0] y;
    } exp_t;

    exp_t        sb[$];
    logic        grants[$];
    int          compared   = 0;
    int          mismatched = 0;
    int          cycle      = 0;
    int          accept_cycle = 0;
    int          rsp_seen   = 0;
    logic        prev_rsp_valid = 1'b0;
    logic [31:0] hold_y;
    logic        hold_id;
    logic        keep0 = 1'b0;
    logic        keep1 = 1'b0;
    logic        s_ready0, s_ready1;

    always #5 clk = ~clk;

    shift_arbiter #(.RR_INIT(1'b0)) dut (
        .clk        (clk),
        .rst        (rst),
        .req0_valid (req0_valid),
        .req0_d     (req0_d),
        .req0_s     (req0_s),
        .req0_lnr   (req0_lnr),
        .req0_ready (req0_ready),
        .req1_valid (req1_valid),
        .req1_d     (req1_d),
        .req1_s     (req1_s),
        .req1_lnr   (req1_lnr),
        .req1_ready (req1_ready),
        .rsp_valid  (rsp_valid),
        .rsp_id     (rsp_id),
        .rsp_y      (rsp_y),
        .rsp_ready  (rsp_ready)
    );

    // Reference: logical shift, anything of 32 or more empties the word.
    function automatic logic [31:0] modelShift(input logic [31:0] d,
                                               input logic [31:0] s,
                                               input logic lnr);
        if (s > 32'd31) return 32'h0;
        return lnr ? (d << s) : (d >> s);
    endfunction

    task automatic compare(input string tag, input logic [31:0] obs,
                           input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input int who, input logic [31:0] d,
                                 input logic [31:0] s, input logic lnr);
        if (who == 0) begin
            req0_valid = 1'b1; req0_d = d; req0_s = s; req0_lnr = lnr;
        end else begin
            req1_valid = 1'b1; req1_d = d; req1_s = s; req1_lnr = lnr;
        end
    endtask

    // One cycle: sample just after the falling edge, score, advance.
    task automatic checkOutput();
        logic r0, r1;
        exp_t e;
        #1;
        r0 = req0_ready;
        r1 = req1_ready;
        s_ready0 = r0;
        s_ready1 = r1;
        compare("ready_onehot", {31'b0, r0 & r1}, 32'h0);
        if (rsp_valid) compare("ready_while_busy", {31'b0, r0 | r1}, 32'h0);
        if (r0 | r1) begin
            e.id = r1;
            e.y  = r1 ? modelShift(req1_d, req1_s, req1_lnr)
                      : modelShift(req0_d, req0_s, req0_lnr);
            sb.push_back(e);
            grants.push_back(r1);
            accept_cycle = cycle;
        end
        if (rsp_valid && !prev_rsp_valid)
            compare("latency", cycle - accept_cycle, 32'd2);
        if (rsp_valid && prev_rsp_valid) begin
            compare("hold_y", rsp_y, hold_y);
            compare("hold_id", {31'b0, rsp_id}, {31'b0, hold_id});
        end
        if (rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                compare("unexpected_rsp", {31'b0, rsp_valid}, 32'h0);
            end else begin
                e = sb.pop_front();
                compare("rsp_y", rsp_y, e.y);
                compare("rsp_id", {31'b0, rsp_id}, {31'b0, e.id});
            end
        end
        if (rsp_valid) rsp_seen++;
        prev_rsp_valid = rsp_valid;
        hold_y  = rsp_y;
        hold_id = rsp_id;
        @(negedge clk);
        cycle++;
        if (r0 && !keep0) req0_valid = 1'b0;
        if (r1 && !keep1) req1_valid = 1'b0;
    endtask

    task automatic waitDone(input string tag, input int maxc);
        int n = 0;
        while ((sb.size() != 0 || req0_valid || req1_valid) && n < maxc) begin
            checkOutput();
            n++;
        end
        compare(tag, {31'b0, n < maxc}, 32'h1);
    endtask

    initial begin
        rst = 1'b1;
        req0_valid = 1'b1; req0_d = '0; req0_s = '0; req0_lnr = 1'b0;
        req1_valid = 1'b0; req1_d = '0; req1_s = '0; req1_lnr = 1'b0;
        rsp_ready = 1'b1;

        // Reset state, with a request pending that must not be acknowledged.
        repeat (2) @(negedge clk);
        #1;
        compare("reset_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        compare("reset_rsp_y", rsp_y, 32'h0);
        compare("reset_rsp_id", {31'b0, rsp_id}, 32'h0);
        compare("reset_ready0", {31'b0, req0_ready}, 32'h0);
        @(negedge clk);

        // Contention: both held for four operations, accepted on first edge.
        $display("[TB] contention");
        applyStimulus(0, 32'h0000_0003, 32'd1, 1'b1);
        applyStimulus(1, 32'h0000_0100, 32'd4, 1'b0);
        keep0 = 1'b1;
        keep1 = 1'b1;
        rst = 1'b0;
        checkOutput();
        compare("first_edge_accept", {31'b0, s_ready0}, 32'h1);
        begin
            int n = 0;
            while (grants.size() < 4 && n < 40) begin
                checkOutput();
                n++;
            end
            compare("contention_timeout", {31'b0, n < 40}, 32'h1);
        end
        keep0 = 1'b0;
        keep1 = 1'b0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        waitDone("contention_drain", 20);
        compare("grant_count", grants.size(), 32'd4);
        if (grants.size() == 4) begin
            compare("grant_order0", {31'b0, grants[0]}, 32'h0);
            compare("grant_order1", {31'b0, grants[1]}, 32'h1);
            compare("grant_order2", {31'b0, grants[2]}, 32'h0);
            compare("grant_order3", {31'b0, grants[3]}, 32'h1);
        end

        // Single left shift and right shift by 31.
        $display("[TB] basic shifts");
        applyStimulus(0, 32'h0000_0001, 32'd4, 1'b1);
        waitDone("left_done", 20);
        applyStimulus(1, 32'h8000_0000, 32'd31, 1'b0);
        waitDone("right31_done", 20);

        // Amounts of 32 and above, including one whose low bits are small.
        $display("[TB] large amounts");
        applyStimulus(0, 32'hFFFF_FFFF, 32'h0000_0020, 1'b1);
        waitDone("big32_done", 20);
        applyStimulus(0, 32'hFFFF_FFFF, 32'h8000_0003, 1'b1);
        waitDone("bigtop_done", 20);

        // Backpressure: result held five cycles while requester 1 waits.
        $display("[TB] backpressure");
        rsp_ready = 1'b0;
        applyStimulus(0, 32'h1234_5678, 32'd8, 1'b0);
        checkOutput();
        applyStimulus(1, 32'hA5A5_0000, 32'd16, 1'b0);
        begin
            int n = 0;
            while (!rsp_valid && n < 10) begin
                checkOutput();
                n++;
            end
            compare("bp_rsp_timeout", {31'b0, rsp_valid}, 32'h1);
        end
        repeat (5) checkOutput();
        rsp_ready = 1'b1;
        checkOutput();
        checkOutput();
        compare("bp_accept_next", {31'b0, s_ready1}, 32'h1);
        waitDone("bp_drain", 20);

        // Reset during SHIFT discards the operation.
        $display("[TB] reset mid-operation");
        applyStimulus(0, 32'h0000_00F0, 32'd4, 1'b1);
        checkOutput();
        rst = 1'b1;
        #1;
        compare("midrst_rsp_valid", {31'b0, rsp_valid}, 32'h0);
        compare("midrst_rsp_y", rsp_y, 32'h0);
        compare("midrst_rsp_id", {31'b0, rsp_id}, 32'h0);
        sb.delete();
        prev_rsp_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        rsp_seen = 0;
        repeat (4) checkOutput();
        compare("midrst_no_rsp", rsp_seen, 32'd0);
        applyStimulus(1, 32'h0000_00FF, 32'd0, 1'b1);
        waitDone("after_reset_done", 20);
        compare("scoreboard_empty", sb.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/shift_arbiter.md
SHIFT_ARBITER -- requirements
Module: shift_arbiter

Interface
REQ-001 The block SHALL have parameter RR_INIT, default 0: requester given priority first after reset (0 or 1).
REQ-002 The block SHALL have port CLK  input  1  sole clock, rising-edge.
REQ-003 The block SHALL have port RST  input  1  reset, asynchronous, active-high.
REQ-004 The block SHALL have port REQ0_VALID  input  1  requester 0 has an operation.
REQ-005 The block SHALL have port REQ0_D  input  32  requester 0 data operand.
REQ-006 The block SHALL have port REQ0_S  input  32  requester 0 shift amount, full 32-bit.
REQ-007 The block SHALL have port REQ0_LNR  input  1  requester 0 direction: 1 = left, 0 = right, logical.
REQ-008 The block SHALL have port REQ0_READY  output  1  requester 0 operation accepted this cycle.
REQ-009 The block SHALL have ports REQ1_VALID, REQ1_D, REQ1_S, REQ1_LNR and REQ1_READY, identical to REQ-004..REQ-008, for requester 1.
REQ-010 The block SHALL have port RSP_VALID  output  1  result available.
REQ-011 The block SHALL have port RSP_ID  output  1  requester owning the result.
REQ-012 The block SHALL have port RSP_Y  output  32  shifted result.
REQ-013 The block SHALL have port RSP_READY  input  1  consumer takes the result.

Function
REQ-014 The block SHALL implement a three-state FSM: IDLE, SHIFT, RESP.
REQ-015 The grant SHALL be computed as follows:
- In IDLE with exactly one VALID high, that requester is granted.
- With both VALID high, the requester not served last is granted.
- The last-served pointer updates only on acceptance.
REQ-016 REQx_READY SHALL equal (state==IDLE) & VALIDx & grantx & !RST, combinationally; at most one READY is high per cycle.
REQ-017 On acceptance the block SHALL:
- register D, LNR and ID;
- register S[4:0] as the 5-bit amount;
- register the flag BIG = (S[31:5] != 0);
- move to SHIFT.
REQ-018 In SHIFT the registered operands SHALL drive the shifter; RSP_Y SHALL be loaded with 0 if BIG, else the shifter output; RSP_ID SHALL be loaded with the registered ID; the FSM SHALL then move to RESP.
REQ-019 In RESP, RSP_VALID SHALL be 1, and RSP_Y and RSP_ID SHALL hold stable until RSP_READY=1; that cycle the FSM SHALL return to IDLE.
REQ-020 The latency from acceptance edge to RSP_VALID=1 SHALL be exactly 2 cycles; throughput SHALL be at most one operation per 3 cycles.
REQ-021 RSP_VALID SHALL be 0 in IDLE and SHIFT.
REQ-022 No request SHALL be accepted in SHIFT or RESP; requesters hold VALID and operands until READY.
REQ-023 A shift amount of 0 SHALL return D unchanged; an amount of 31 SHALL leave one bit; amounts of 32 and above SHALL return 0.
REQ-024 Changes on REQx inputs while not READY SHALL NOT affect the in-flight result.

Reset
REQ-025 While RST=1, asynchronously, the block SHALL force:
- state=IDLE;
- RSP_VALID=0, RSP_Y=0, RSP_ID=0;
- operand registers=0, BIG=0;
- last-served pointer = !RR_INIT;
- REQ0_READY=REQ1_READY=0.
REQ-026 An RST assertion mid-operation, in SHIFT or RESP, SHALL discard the operation without a response.
REQ-027 On the first edge after RST deasserts, acceptance SHALL be possible if VALID is high.

Structure
REQ-028 The FSM state encodings and the BIG threshold (32) SHALL be defined once in the shared project definitions file.
REQ-029 The block SHALL instantiate exactly one BARREL_SHIFTER32 (D, 5-bit S, LnR) as its sole sub-module; no other shift logic is permitted.

Verification
REQ-030 The bench SHALL cover a single left shift:
- Stimulus: REQ0 D=0x0000_0001, S=4, LNR=1; RSP_READY=1.
- Response: RSP_VALID 2 cycles after acceptance; RSP_Y=0x0000_0010; RSP_ID=0.
REQ-031 The bench SHALL cover a right shift by 31:
- Stimulus: REQ1 D=0x8000_0000, S=31, LNR=0.
- Response: RSP_Y=0x0000_0001; RSP_ID=1.
REQ-032 The bench SHALL cover a large amount:
- Stimulus: REQ0 D=0xFFFF_FFFF, S=0x0000_0020, then S=0x8000_0003.
- Response: RSP_Y=0 in both cases.
REQ-033 The bench SHALL cover contention:
- Stimulus: both VALID held for 4 operations with RR_INIT=0.
- Response: grant order 0,1,0,1; READY never high for both in one cycle.
REQ-034 The bench SHALL cover backpressure:
- Stimulus: RSP_READY=0 for 5 cycles in RESP, with REQ1 VALID.
- Response: RSP_Y/RSP_ID stable; REQ1_READY=0 throughout; acceptance in the cycle after RSP_READY=1.
REQ-035 The bench SHALL cover reset mid-operation:
- Stimulus: assert RST during SHIFT.
- Response: RSP_VALID=0 and RSP_Y=0 immediately; no response after release; next request completes normally.
